wallace_mac_accum: RTL
======================

// Module: wallace_mac_accum
// PURPOSE
// - Consumes the carry-save pair (out0/out1) from the 8x8 radix-4 Booth Wallace tree (wallace_i5c) of one systolic PE.
// - Resolves the pair into a signed 16-bit product (stage 1), then accumulates the product into a signed dot-product accumulator (stage 2).
// - Emits the finished sum through a valid/ready result port with one result buffer.
// PARAMETERS
// - CS0_W     14  width of carry-save sum vector (weight of bit k = 2^k)
// - CS1_W     12  width of carry-save carry vector
// - CS1_SHIFT 3   weight offset of cs1[0] (cs1[j] weight = 2^(j+3))
// - PROD_W    16  product width; product = (cs0 + (cs1<<CS1_SHIFT)) mod 2^PROD_W, two's complement
// - ACC_W     32  accumulator/result width; the product is sign-extended to ACC_W
// PORTS
// - clk        in   1       single clock, rising edge
// - rst        in   1       asynchronous, active-high reset
// - in_valid   in   1       cs pair valid
// - in_ready   out  1       stage accepts the pair this cycle
// - in_first   in   1       pair starts a new dot product (accumulator loads instead of adding)
// - in_last    in   1       pair ends the dot product (result produced)
// - cs0        in   CS0_W   tree out0
// - cs1        in   CS1_W   tree out1
// - res_valid  out  1       result valid
// - res_ready  in   1       consumer takes result
// - res_data   out  ACC_W   signed dot-product result
// - res_ovf    out  1       overflow occurred during this dot product
// BEHAVIOUR
// - Reset: all pipeline valids 0, acc 0, res_valid 0, res_data 0, res_ovf 0, sticky ovf 0. in_ready = 1 one cycle after rst deasserts.
// - Transfer on in_valid & in_ready. S1 registers {prod, first, last}; S2 updates acc the cycle after. Latency from accepted last pair to res_valid = 2 cycles.
// - S2 rule: first ? acc <= sext(prod) : acc <= acc + sext(prod); sticky ovf cleared on first, set on signed overflow.
// - first & last on the same pair: single-term dot product; result = sext(prod).
// - On S2 last: res_data <= new acc value, res_ovf <= new sticky ovf, res_valid <= 1; acc keeps its value until the next first.
// - Result buffer holds one entry; res_valid stays high and res_data is stable until res_ready.
// - Backpressure: in_ready = !(s1_valid & s1_last & res_valid & !res_ready) && !(s2 stall); the pipe never drops or duplicates a pair; a last may only enter S2 when the buffer is empty or drains that cycle.
// - Simultaneous res_ready and a new S2 last in the same cycle: old result retires, new one loads, res_valid stays 1.
// - Pair without a preceding first: adds into the current acc (defined, not an error).
// - rst mid-operation: partial acc and buffered result are discarded; no spurious res_valid.
// CONFIGURATION
// - SATURATE_EN defined: on signed overflow acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and stays clamped for the rest of the dot product; res_ovf is reported.
// - SATURATE_EN undefined: acc wraps mod 2^ACC_W; res_ovf is still reported.
// STRUCTURE
// - Shared package wallace_pkg: CS0_W/CS1_W/CS1_SHIFT/PROD_W defaults, typedef prod_t (signed [PROD_W-1:0]), typedef acc_t (signed [ACC_W-1:0]), SAT_MAX/SAT_MIN constants.
// - One sub-module: cs_resolve (combinational carry-propagate adder, cs0 + (cs1<<CS1_SHIFT) truncated to PROD_W); S1 registers its output.
// - Top: S1 register, S2 accumulator with overflow logic, result buffer, ready logic.
// TESTING
// - Reset release: after rst deassert res_valid=0, res_data=0, in_ready=1; no output before first input.
// - Single term: cs pair for 7*(-3) (cs0=16'hFFEB-equivalent split, cs1=0) with first=last=1 -> res_data=-21, res_ovf=0, res_valid 2 cycles later.
// - 4-term dot product 1*2+3*4+(-5)*6+127*127 via real tree vectors, back-to-back -> res_data=16113.
// - Backpressure: hold res_ready=0, issue two dot products -> in_ready drops, second result held; release res_ready -> results 16113 then -21 in order, none lost.
// - Overflow: ACC_W=17 build, accumulate 8 x (127*127) -> SATURATE_EN: res_data=65535, res_ovf=1; else wrapped value (129032 mod 2^17 as signed = -2040), res_ovf=1.
// - Reset mid-dot-product after 2 terms, then new first/last 2*2 -> res_data=4, no stale result emitted.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared widths and types for the Booth/Wallace PE datapath.
// Defaults describe the 8x8 radix-4 tree: 14-bit sum and 12-bit carry vectors.
// The carry vector is offset by CS1_SHIFT bit positions.
package wallace_pkg;

  localparam int CS0_W     = 14;
  localparam int CS1_W     = 12;
  localparam int CS1_SHIFT = 3;
  localparam int PROD_W    = 16;
  localparam int ACC_W     = 32;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Clamp limits for the default accumulator width.
  localparam acc_t SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/wallace_mac_accum_cs_resolve.sv
// cs_resolve: carry-propagate add of the tree's sum/carry vectors into a PROD_W product.
// Latency: combinational; the top registers the result in S1.
// Backpressure: none, pure function of its inputs.
module cs_resolve
  import wallace_pkg::*;
#(
  parameter int CS0_W     = wallace_pkg::CS0_W,
  parameter int CS1_W     = wallace_pkg::CS1_W,
  parameter int CS1_SHIFT = wallace_pkg::CS1_SHIFT,
  parameter int PROD_W    = wallace_pkg::PROD_W
) (
  input  logic [CS0_W-1:0]  cs0,
  input  logic [CS1_W-1:0]  cs1,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] ext0;
  logic [PROD_W-1:0] ext1;

  // Both tree vectors are two's complement with their MSB as sign, so they
  // are sign-extended before the add; the sum wraps mod 2^PROD_W.
  always_comb begin
    ext0 = PROD_W'($signed(cs0));
    ext1 = PROD_W'($signed(cs1)) << CS1_SHIFT;
    prod = ext0 + ext1;
  end

endmodule

// File: rtl/wallace_mac_accum.sv
// wallace_mac_accum: resolves the tree's carry-save pair and accumulates signed dot products.
// Latency: an accepted last pair shows res_valid two cycles later; one pair per cycle otherwise.
// Backpressure: a last pair waits in S1 while the one-entry result buffer is full; in_ready drops.
// Optional macro SATURATE_EN: clamp the accumulator on signed overflow instead of wrapping.
module wallace_mac_accum
  import wallace_pkg::*;
#(
  parameter int CS0_W     = wallace_pkg::CS0_W,
  parameter int CS1_W     = wallace_pkg::CS1_W,
  parameter int CS1_SHIFT = wallace_pkg::CS1_SHIFT,
  parameter int PROD_W    = wallace_pkg::PROD_W,
  parameter int ACC_W     = wallace_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [CS0_W-1:0]  cs0,
  input  logic [CS1_W-1:0]  cs1,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [PROD_W-1:0]        cs_prod;
  logic                     live;

  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;
  logic [PROD_W-1:0]        s1_prod;

  logic signed [ACC_W-1:0]  acc;
  logic                     sticky;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     add_ovf;
  logic                     sticky_nxt;
  logic                     s2_stall;
  logic                     s2_fire;

  cs_resolve #(
    .CS0_W    (CS0_W),
    .CS1_W    (CS1_W),
    .CS1_SHIFT(CS1_SHIFT),
    .PROD_W   (PROD_W)
  ) u_cs_resolve (
    .cs0 (cs0),
    .cs1 (cs1),
    .prod(cs_prod)
  );

  // A last pair may only leave S1 if the result buffer is empty or draining now.
  always_comb begin
    s2_stall = s1_valid & s1_last & res_valid & ~res_ready;
    s2_fire  = s1_valid & ~s2_stall;
    in_ready = live & ~s2_stall;
  end

  // Accumulate with one guard bit; overflow shows as a mismatch of the top two
  // bits. A first pair adds to zero and therefore can never overflow.
  always_comb begin
    prod_ext   = ACC_W'($signed(s1_prod));
    base       = s1_first ? '0 : acc;
    sum_wide   = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};
    add_ovf    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sticky_nxt = (~s1_first & sticky) | add_ovf;
`ifdef SATURATE_EN
    // Once clamped, the accumulator holds its limit until the next first pair.
    if (~s1_first & sticky) begin
      acc_nxt = acc;
    end else if (add_ovf) begin
      acc_nxt = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_nxt = sum_wide[ACC_W-1:0];
    end
`else
    acc_nxt = sum_wide[ACC_W-1:0];
`endif
  end

  // Input acceptance opens one cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  // S1: capture the resolved product; hold it while S2 is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_prod  <= cs_prod;
    end
  end

  // S2: accumulator and sticky overflow flag for the current dot product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (s2_fire) begin
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
    end
  end

  // Result buffer: a finishing pair loads it (even while the old entry
  // retires this cycle); otherwise the consumer empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
    end else if (s2_fire & s1_last) begin
      res_valid <= 1'b1;
      res_data  <= acc_nxt;
      res_ovf   <= sticky_nxt;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
